// File: rtl/tess_prim_assembler.sv
// Assembles triangles from a row-major tessellator domain-point stream.
// The previous row lives in a ping-pong bank pair; each triangle is offered through a ready/valid handshake.
module tess_prim_assembler #(
    parameter int MAX_LEVEL = 64,
    parameter int CW        = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      cfg_level,
    input  logic [1:0]      cfg_mode,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [3*CW-1:0] in_coord,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [3*CW-1:0] tri_v0,
    output logic [3*CW-1:0] tri_v1,
    output logic [3*CW-1:0] tri_v2,
    output logic            tri_valid,
    input  logic            tri_ready,
    output logic            tri_last,
    output logic            busy
);
    localparam int AW = $clog2(MAX_LEVEL + 1);
    localparam int PW = 3 * CW;
    localparam logic [AW-1:0] ONE  = AW'(1);
    localparam logic [AW-1:0] LMAX = AW'(MAX_LEVEL);

    typedef enum logic [1:0] {IDLE, ACCEPT, EMIT_A, EMIT_B} state_t;

    state_t          state, state_nx;
    logic [AW-1:0]   n_lvl, i_cnt, j_cnt, j_max, j_dec, j_inc;
    logic            quad, has_b, last_pt;
    logic            accept, cfg_take, row_end, last_now, forms, two;
    logic            ub;
    logic [PW-1:0]   prev, b_v0, b_v1, b_v2;
    logic [PW-1:0]   u_jm1, u_j, u_jp1;
    logic [PW-1:0]   a0_nx, a1_nx, a2_nx, b0_nx, b1_nx, b2_nx;
    logic [PW-1:0]   bank [2][MAX_LEVEL+1];

    function automatic logic [AW-1:0] clamp_level(input logic [7:0] lvl);
        if (lvl == 8'd0)
            return ONE;
        else if (int'(lvl) > MAX_LEVEL)
            return LMAX;
        else
            return AW'(lvl);
    endfunction

    assign cfg_ready = (state == IDLE);
    assign in_ready  = (state == ACCEPT);
    assign tri_valid = (state == EMIT_A) || (state == EMIT_B);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign cfg_take  = cfg_valid && cfg_ready;

    // Row i-1 sits in the bank not selected by i[0]; guard the neighbour indices at the ends
    assign ub       = ~i_cnt[0];
    assign j_max    = quad ? n_lvl : (n_lvl - i_cnt);
    assign row_end  = (j_cnt == j_max);
    assign last_now = row_end && (i_cnt == n_lvl);
    assign forms    = (i_cnt != '0) && (!quad || (j_cnt != '0));
    assign two      = (i_cnt != '0) && (j_cnt != '0);
    assign j_dec    = (j_cnt == '0) ? j_cnt : (j_cnt - ONE);
    assign j_inc    = (j_cnt == LMAX) ? j_cnt : (j_cnt + ONE);
    assign u_jm1    = bank[ub][j_dec];
    assign u_j      = bank[ub][j_cnt];
    assign u_jp1    = bank[ub][j_inc];

    always_comb begin
        a0_nx = u_j;
        a1_nx = prev;
        a2_nx = in_coord;
        b0_nx = u_j;
        b1_nx = u_jp1;
        b2_nx = in_coord;
        if (quad) begin
            a0_nx = u_jm1;
            a1_nx = prev;
            a2_nx = u_j;
            b1_nx = prev;
        end else if (j_cnt == '0) begin
            a1_nx = u_jp1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cfg_take) state_nx = ACCEPT;
            ACCEPT:  if (accept) begin
                         if (forms)
                             state_nx = EMIT_A;
                         else if (last_now)
                             state_nx = IDLE;
                     end
            EMIT_A:  if (tri_ready) begin
                         if (has_b)
                             state_nx = EMIT_B;
                         else
                             state_nx = last_pt ? IDLE : ACCEPT;
                     end
            EMIT_B:  if (tri_ready) state_nx = last_pt ? IDLE : ACCEPT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_lvl    <= ONE;
            quad     <= 1'b0;
            i_cnt    <= '0;
            j_cnt    <= '0;
            has_b    <= 1'b0;
            last_pt  <= 1'b0;
            tri_last <= 1'b0;
            tri_v0   <= '0;
            tri_v1   <= '0;
            tri_v2   <= '0;
        end else begin
            if (cfg_take) begin
                n_lvl <= clamp_level(cfg_level);
                quad  <= (cfg_mode != 2'd0);
                i_cnt <= '0;
                j_cnt <= '0;
            end
            if (accept) begin
                if (row_end) begin
                    j_cnt <= '0;
                    i_cnt <= i_cnt + ONE;
                end else begin
                    j_cnt <= j_cnt + ONE;
                end
                if (forms) begin
                    tri_v0   <= a0_nx;
                    tri_v1   <= a1_nx;
                    tri_v2   <= a2_nx;
                    tri_last <= last_now && !two;
                    has_b    <= two;
                    last_pt  <= last_now;
                end
            end
            if (tri_valid && tri_ready) begin
                if ((state == EMIT_A) && has_b) begin
                    tri_v0   <= b_v0;
                    tri_v1   <= b_v1;
                    tri_v2   <= b_v2;
                    tri_last <= last_pt;
                end else begin
                    tri_last <= 1'b0;
                end
            end
        end
    end

    // Point storage and the second-triangle staging are data only
    always_ff @(posedge clk) begin
        if (accept) begin
            bank[i_cnt[0]][j_cnt] <= in_coord;
            prev <= in_coord;
            b_v0 <= b0_nx;
            b_v1 <= b1_nx;
            b_v2 <= b2_nx;
        end
    end
endmodule
